// File: rtl/serial_frame_rx.sv
// Framed MSB-first serial receiver into a one-entry valid/ready output register; parity via SERIAL_FRAME_RX_PARITY_EN.
// Latency: q_valid rises the cycle after the stop-bit sample; error pulses land in that same cycle.
// Backpressure: a completed frame that finds the output full and not draining is dropped and flagged by overrun.
module serial_frame_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             bit_en,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic             load;
  logic             frame_err_nxt;
  logic             overrun_nxt;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par_bit, par_bit_nxt;
  logic parity_err_nxt;
  logic parity_bad;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign parity_bad = ^{shreg, par_bit};
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    shreg_nxt     = shreg;
    load          = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_bit_nxt    = par_bit;
    parity_err_nxt = 1'b0;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          if (sin) begin
            state_nxt = DATA;
            cnt_nxt   = '0;
          end
        end
        DATA: begin
          shreg_nxt = {shreg[WIDTH-2:0], sin};
          cnt_nxt   = cnt + CW'(1);
          if (cnt == LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = STOP;
`endif
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        PAR: begin
          par_bit_nxt = sin;
          state_nxt   = STOP;
        end
`endif
        STOP: begin
          state_nxt = IDLE;
          // Stop-bit failure outranks parity; a good frame may land in a slot draining this same edge.
          if (sin) begin
            frame_err_nxt = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          end else if (parity_bad) begin
            parity_err_nxt = 1'b1;
`endif
          end else if (!q_valid || q_ready) begin
            load = 1'b1;
          end else begin
            overrun_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      q_data    <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      shreg     <= shreg_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
      if (load) begin
        q_data  <= shreg;
        q_valid <= 1'b1;
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_bit_nxt;
      parity_err <= parity_err_nxt;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random traffic, scored against a frame-level reference model.
module tb_serial_frame_rx;
  localparam int W = 4;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  localparam int DLV = 0, FERR = 1, OVR = 2, PERR = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         sin = 1'b0;
  logic         bit_en = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q_data;
  logic         q_valid;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .sin(sin), .bit_en(bit_en),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 1;
  bit gaps = 1'b0;

  typedef struct {
    int           kind;
    logic [W-1:0] data;
    int           cyc;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: collects sampled bits per frame and decides each frame's fate.
  bit   in_frame = 1'b0;
  bit   out_full = 1'b0;
  logic bits[$];
  bit   m_acc, m_dlv;
  int   m_ones;
  ev_t  m_ev;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      out_full = 1'b0;
      bits.delete();
    end else begin
      cyc++;
      m_acc = out_full && q_ready;
      m_dlv = 1'b0;
      if (bit_en) begin
        if (!in_frame) begin
          if (sin) begin
            in_frame = 1'b1;
            bits.delete();
          end
        end else begin
          bits.push_back(sin);
          if (bits.size() == W + NPAR + 1) begin
            in_frame = 1'b0;
            m_ev.cyc = cyc;
            m_ev.data = '0;
            m_ones = 0;
            for (int i = 0; i < W; i++) m_ev.data[W-1-i] = bits[i];
            for (int i = 0; i < W + NPAR; i++) m_ones += int'(bits[i]);
            if (bits[W+NPAR]) m_ev.kind = FERR;
            else if (NPAR == 1 && (m_ones % 2) == 1) m_ev.kind = PERR;
            else if (!out_full || q_ready) begin
              m_ev.kind = DLV;
              m_dlv = 1'b1;
            end else m_ev.kind = OVR;
            exp_q.push_back(m_ev);
          end
        end
      end
      if (m_dlv) out_full = 1'b1;
      else if (m_acc) out_full = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [W-1:0] cur_exp = '0;

  task automatic expect_ev(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL outcome: DUT showed kind %0d data %0h at cycle %0d, model expected nothing", kind, q_data, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == DLV && e.data !== q_data)) begin
        errors++;
        $display("FAIL outcome: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                 kind, q_data, cyc, e.kind, e.data, e.cyc);
      end
      if (kind == DLV) cur_exp = e.data;
    end
  endtask

  // Monitor: each new word on the output and each error pulse consumes one model outcome.
  logic prev_v = 1'b0, prev_acc = 1'b0;
  bit   fresh;
  int   nout;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v   = 1'b0;
      prev_acc = 1'b0;
    end else begin
      fresh = q_valid && (!prev_v || prev_acc);
      nout  = int'(fresh) + int'(frame_err) + int'(overrun) + int'(parity_err);
      if (nout > 1) check("one_outcome_per_cycle", nout, 1);
      if (fresh) expect_ev(DLV);
      else if (q_valid) check("held_data", q_data, cur_exp);
      if (prev_v && !prev_acc) check("valid_held", q_valid, 1'b1);
      if (frame_err) expect_ev(FERR);
      if (overrun) expect_ev(OVR);
      if (parity_err) expect_ev(PERR);
      prev_v   = q_valid;
      prev_acc = q_valid && q_ready;
    end
  end

  function automatic logic pick_rdy();
    if (rdy_mode == 0) return 1'b0;
    if (rdy_mode == 1) return 1'b1;
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic s, input logic en, input logic r);
    sin = s;
    bit_en = en;
    q_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int rdy_ovr);
    while (gaps && $urandom_range(0, 2) == 0) step(b, 1'b0, pick_rdy());
    step(b, 1'b1, (rdy_ovr == 2) ? pick_rdy() : logic'(rdy_ovr == 1));
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic bad_par, input int stop_rdy);
    send_bit(1'b1, 2);
    for (int i = W - 1; i >= 0; i--) send_bit(d[i], 2);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_bit((^d) ^ bad_par, 2);
`endif
    send_bit(stop, stop_rdy);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, pick_rdy());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q_data"}, q_data, 0);
    check({tag, "_q_valid"}, q_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_parity_err"}, parity_err, 0);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_all_zero("reset");
    reset_n = 1'b1;

    rdy_mode = 1;
    idle(2);
    send_frame(4'b1101, 1'b0, 1'b0, 2);
    idle(3);

    gaps = 1'b1;
    send_frame(4'b1101, 1'b0, 1'b0, 2);
    gaps = 1'b0;
    idle(3);

    send_frame(4'b0110, 1'b1, 1'b0, 2);
    send_frame(4'b0011, 1'b0, 1'b0, 2);
    idle(3);

    rdy_mode = 0;
    send_frame(4'b1101, 1'b0, 1'b0, 2);
    send_frame(4'b0110, 1'b0, 1'b0, 2);
    idle(3);
    check("overrun_kept_q_data", q_data, 4'b1101);
    check("overrun_kept_q_valid", q_valid, 1'b1);
    rdy_mode = 1;
    idle(2);
    rdy_mode = 0;
    send_frame(4'b1101, 1'b0, 1'b0, 2);
    send_frame(4'b0110, 1'b0, 1'b0, 1);
    idle(2);
    check("drain_q_data", q_data, 4'b0110);
    check("drain_q_valid", q_valid, 1'b1);
    rdy_mode = 1;
    idle(2);

    rdy_mode = 0;
    send_frame(4'b1101, 1'b0, 1'b0, 2);
    send_bit(1'b1, 2);
    send_bit(1'b1, 2);
    send_bit(1'b0, 2);
    send_bit(1'b1, 2);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midreset");
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    rdy_mode = 1;
    send_frame(4'b1010, 1'b0, 1'b0, 2);
    idle(3);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_frame(4'b1101, 1'b0, 1'b0, 2);
    send_frame(4'b1101, 1'b0, 1'b1, 2);
    idle(3);
`endif

    repeat (300) begin
      rdy_mode = $urandom_range(0, 2);
      gaps = bit'($urandom_range(0, 1));
      d = W'($urandom);
      send_frame(d, logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 7) == 0), 2);
      idle($urandom_range(0, 2));
    end

    rdy_mode = 1;
    gaps = 1'b0;
    idle(6);
    check("pending_outcomes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
